// File: rtl/gg_bitstream_pkg.sv
// Shared constants and state codes for the gg_bitstream_window re-windowing block.
// Optional feature macro used by the top: GG_BITPOS_EN (adds out_bitpos).
package gg_bitstream_pkg;

    localparam int GG_WORD_W = 32;
    localparam int GG_PAD_W  = 32;

    typedef logic [1:0] gg_state_t;

    localparam gg_state_t GG_FILL   = 2'd0;
    localparam gg_state_t GG_STREAM = 2'd1;
    localparam gg_state_t GG_DRAIN  = 2'd2;

endpackage

// File: rtl/gg_bitstream_window_shift_append.sv
// Left-justified DEPTH-bit buffer: optional shift-left-by-WID, then OR-in a 32-bit word
// at the post-shift fill position (bits past the fill count are always zero).
module gg_shift_append
    import gg_bitstream_pkg::*;
#(
    parameter int DEPTH = 96,
    parameter int WID   = 32,
    parameter int CW    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_shift,
    input  logic                 i_append,
    input  logic [CW-1:0]        i_pos,
    input  logic [GG_WORD_W-1:0] i_data,
    output logic [DEPTH-1:0]     o_buf
);

    logic [DEPTH-1:0] r_buf;
    logic [DEPTH-1:0] w_shifted;
    logic [DEPTH-1:0] w_word;
    logic [DEPTH-1:0] w_next;

    // OR is enough for the append because everything right of i_pos is already zero
    always_comb begin
        w_shifted = i_shift ? (r_buf << WID) : r_buf;
        w_word    = '0;
        if (i_append) begin
            w_word = {i_data, {(DEPTH-GG_WORD_W){1'b0}}} >> i_pos;
        end
        w_next = w_shifted | w_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf <= '0;
        end else if (i_shift || i_append) begin
            r_buf <= w_next;
        end
    end

    assign o_buf = r_buf;

endmodule

// File: rtl/gg_bitstream_window.sv
// Re-windows a 32-bit big-endian word stream into WID-bit beats with 32 bits of lookahead.
// Define GG_BITPOS_EN to add the out_bitpos stream-offset output.
module gg_bitstream_window
    import gg_bitstream_pkg::*;
#(
    parameter int WID = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GG_WORD_W-1:0] in_data,
    input  logic [GG_WORD_W-1:0] in_mb_start,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WID-1:0]       out_bits,
    output logic [GG_PAD_W-1:0]  out_pad,
    output logic [WID-1:0]       out_mb_start,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef GG_BITPOS_EN
    ,
    output logic [31:0]          out_bitpos
`endif
);

    localparam int DEPTH = WID + 64;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] C_WID  = CW'(WID);
    localparam logic [CW-1:0] C_HI   = CW'(WID + GG_PAD_W);
    localparam logic [CW-1:0] C_WORD = CW'(GG_WORD_W);

    gg_state_t        r_state;
    gg_state_t        w_stateNext;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cntShift;
    logic [CW-1:0]    w_cntNext;
    logic             r_live;
    logic             w_inReady;
    logic             w_outValid;
    logic             w_outLast;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_lastFire;
    logic [DEPTH-1:0] w_bits;
    logic [DEPTH-1:0] w_marks;

    // Handshakes come only from registered state, so out_ready never reaches in_ready
    always_comb begin
        w_inReady  = r_live && (r_cnt <= C_HI) && (r_state != GG_DRAIN);
        w_outValid = 1'b0;
        case (r_state)
            GG_STREAM: w_outValid = (r_cnt >= C_HI);
            GG_DRAIN:  w_outValid = (r_cnt != '0);
            default:   w_outValid = 1'b0;
        endcase
        w_outLast  = (r_state == GG_DRAIN) && (r_cnt <= C_WID);
        w_inFire   = in_valid && w_inReady;
        w_outFire  = w_outValid && out_ready;
        w_lastFire = w_outFire && w_outLast;

        // The final beat may hold fewer than WID bits, so it empties the buffer outright
        w_cntShift = r_cnt;
        if (w_lastFire) begin
            w_cntShift = '0;
        end else if (w_outFire) begin
            w_cntShift = r_cnt - C_WID;
        end
        w_cntNext = w_cntShift + (w_inFire ? C_WORD : '0);
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            GG_FILL: begin
                if (w_inFire && in_last) begin
                    w_stateNext = GG_DRAIN;
                end else if (w_cntNext >= C_HI) begin
                    w_stateNext = GG_STREAM;
                end
            end
            GG_STREAM: begin
                if (w_inFire && in_last) begin
                    w_stateNext = GG_DRAIN;
                end
            end
            GG_DRAIN: begin
                if (w_lastFire) begin
                    w_stateNext = GG_FILL;
                end
            end
            default: w_stateNext = GG_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GG_FILL;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_live  <= 1'b1;
        end
    end

    gg_shift_append #(
        .DEPTH (DEPTH),
        .WID   (WID),
        .CW    (CW)
    ) u_bits (
        .clk      (clk),
        .reset    (reset),
        .i_shift  (w_outFire),
        .i_append (w_inFire),
        .i_pos    (w_cntShift),
        .i_data   (in_data),
        .o_buf    (w_bits)
    );

    gg_shift_append #(
        .DEPTH (DEPTH),
        .WID   (WID),
        .CW    (CW)
    ) u_marks (
        .clk      (clk),
        .reset    (reset),
        .i_shift  (w_outFire),
        .i_append (w_inFire),
        .i_pos    (w_cntShift),
        .i_data   (in_mb_start),
        .o_buf    (w_marks)
    );

    assign in_ready     = w_inReady;
    assign out_valid    = w_outValid;
    assign out_last     = w_outLast;
    assign out_bits     = w_bits[DEPTH-1 -: WID];
    assign out_pad      = w_bits[DEPTH-1-WID -: GG_PAD_W];
    assign out_mb_start = w_marks[DEPTH-1 -: WID];

`ifdef GG_BITPOS_EN
    logic [31:0] r_bitpos;

    // Offset of out_bits[WID-1] within the current stream; wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitpos <= '0;
        end else if (w_lastFire) begin
            r_bitpos <= '0;
        end else if (w_outFire) begin
            r_bitpos <= r_bitpos + 32'(WID);
        end
    end

    assign out_bitpos = r_bitpos;
`endif

endmodule

// File: tb/tb_gg_bitstream_window.sv
// Self-checking bench for gg_bitstream_window: a bit-queue model of the stream is
// compared against every DUT output on each falling edge, plus directed literal checks.
module tb_gg_bitstream_window;

    localparam int WID   = 32;
    localparam int DEPTH = WID + 64;
    localparam int BEATW = WID / 32;

    localparam int PH_FILL   = 0;
    localparam int PH_STREAM = 1;
    localparam int PH_DRAIN  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    in_data;
    logic [31:0]    in_mb_start;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic [WID-1:0] out_bits;
    logic [31:0]    out_pad;
    logic [WID-1:0] out_mb_start;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;
`ifdef GG_BITPOS_EN
    logic [31:0]    out_bitpos;
`endif

    int checkCount = 0;
    int errorCount = 0;
    bit monitorOn  = 1'b0;

    // Behavioural model: the not-yet-consumed stream bits, oldest first
    bit          qBits[$];
    bit          qMarks[$];
    int          phase = PH_FILL;
    bit          live  = 1'b0;
    logic [31:0] mBitpos = '0;

    always #5 clk = ~clk;

    gg_bitstream_window #(.WID(WID)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_mb_start  (in_mb_start),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_bits     (out_bits),
        .out_pad      (out_pad),
        .out_mb_start (out_mb_start),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef GG_BITPOS_EN
        ,
        .out_bitpos   (out_bitpos)
`endif
    );

    function automatic bit expReady();
        return live && (phase != PH_DRAIN) && (qBits.size() <= WID + 32);
    endfunction

    function automatic bit expValid();
        if (phase == PH_STREAM) return qBits.size() >= WID + 32;
        if (phase == PH_DRAIN)  return qBits.size() > 0;
        return 1'b0;
    endfunction

    function automatic bit expLast();
        return (phase == PH_DRAIN) && (qBits.size() <= WID);
    endfunction

    function automatic logic [WID+31:0] view(input bit useMarks);
        logic [WID+31:0] v = '0;
        for (int i = 0; i < WID + 32; i++) begin
            if (i < qBits.size()) v[WID+31-i] = useMarks ? qMarks[i] : qBits[i];
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [31:0] mb,
                                 input bit last, input bit rdy);
        in_valid    = v;
        in_data     = d;
        in_mb_start = mb;
        in_last     = last;
        out_ready   = rdy;
    endtask

    // Model update on each rising clock edge, or immediately on reset
    initial begin
        bit inF, outF, lastF;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                qBits.delete();
                qMarks.delete();
                phase   = PH_FILL;
                live    = 1'b0;
                mBitpos = '0;
            end else begin
                inF   = in_valid && expReady();
                outF  = expValid() && out_ready;
                lastF = outF && expLast();
                if (lastF) begin
                    qBits.delete();
                    qMarks.delete();
                    mBitpos = '0;
                end else if (outF) begin
                    repeat (WID) begin
                        void'(qBits.pop_front());
                        void'(qMarks.pop_front());
                    end
                    mBitpos = mBitpos + 32'(WID);
                end
                if (inF) begin
                    for (int i = 31; i >= 0; i--) begin
                        qBits.push_back(in_data[i]);
                        qMarks.push_back(in_mb_start[i]);
                    end
                end
                if (phase == PH_DRAIN) begin
                    if (lastF) phase = PH_FILL;
                end else if (inF && in_last) begin
                    phase = PH_DRAIN;
                end else if (phase == PH_FILL && qBits.size() >= WID + 32) begin
                    phase = PH_STREAM;
                end
                live = 1'b1;
            end
        end
    end

    // Compare process: every output against the model on every falling edge
    initial begin
        logic [WID+31:0] vb, vm;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                vb = view(1'b0);
                vm = view(1'b1);
                checkOutput("in_ready", in_ready, expReady());
                checkOutput("out_valid", out_valid, expValid());
                checkOutput("out_last", out_last, expLast());
                checkOutput("out_bits", out_bits, vb[WID+31:32]);
                checkOutput("out_pad", out_pad, vb[31:0]);
                checkOutput("out_mb_start", out_mb_start, vm[WID+31:32]);
`ifdef GG_BITPOS_EN
                checkOutput("out_bitpos", out_bitpos, mBitpos);
`endif
            end
        end
    end

    // Directed stream of n words with a mark on word 0 and in_last on the final word
    task automatic runVector(input int n);
        logic [31:0]    vec [0:15];
        logic [WID-1:0] firstExp;
        int sent = 0, beats = 0, cyc = 0, firstValidCyc = -1;
        int expBeats = (32 * n + WID - 1) / WID;
        bit done = 1'b0, fireIn;
        for (int i = 0; i < n; i++) vec[i] = $urandom | 32'h1;
        for (int k = 0; k < BEATW; k++) firstExp[WID-1-32*k -: 32] = vec[k];
        while (!done && cyc < 200) begin
            applyStimulus(sent < n, (sent < n) ? vec[sent] : 32'h0,
                          (sent == 0) ? 32'h8000_0000 : 32'h0, sent == n - 1, 1'b1);
            @(negedge clk);
            if (out_valid) begin
                if (firstValidCyc < 0) firstValidCyc = cyc;
                if (beats == 0) begin
                    checkOutput("vec_first_bits", out_bits, firstExp);
                    checkOutput("vec_first_pad", out_pad, vec[BEATW]);
                    checkOutput("vec_first_mark", out_mb_start[WID-1], 1'b1);
`ifdef GG_BITPOS_EN
                    checkOutput("vec_bitpos0", out_bitpos, 32'd0);
`endif
                end else begin
                    checkOutput("vec_later_marks", out_mb_start, '0);
`ifdef GG_BITPOS_EN
                    if (beats == 1) checkOutput("vec_bitpos1", out_bitpos, 32'(WID));
`endif
                end
                if (out_last) begin
                    checkOutput("vec_last_index", beats, expBeats - 1);
                    checkOutput("vec_last_pad", out_pad, 32'h0);
                    done = 1'b1;
                end
                beats++;
            end
            fireIn = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fireIn) sent++;
            cyc++;
        end
        checkOutput("vec_completed", done, 1'b1);
        checkOutput("vec_first_valid_cycle", firstValidCyc, BEATW + 1);
        checkOutput("vec_idle_after_last", out_valid, 1'b0);
`ifdef GG_BITPOS_EN
        checkOutput("vec_bitpos_cleared", out_bitpos, 32'd0);
`endif
    endtask

    // Consumer stalled: buffer fills to DEPTH, in_ready drops, held beat must not move
    task automatic stallTest();
        int accepted = 0;
        bit haveSnap = 1'b0, fireIn;
        logic [WID-1:0] snap = '0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 32'hC0DE_0000 + 32'(c), 32'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (out_valid) begin
                if (!haveSnap) begin
                    snap     = out_bits;
                    haveSnap = 1'b1;
                end else begin
                    checkOutput("stall_bits_stable", out_bits, snap);
                end
            end
            fireIn = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (fireIn) accepted++;
        end
        checkOutput("stall_words_accepted", accepted, DEPTH / 32);
        checkOutput("stall_in_ready_low", in_ready, 1'b0);
        checkOutput("stall_beat_held", haveSnap, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset while a drained stream is still waiting to be consumed
    task automatic resetDrainTest();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int w = 0; w <= BEATW; w++) begin
            applyStimulus(1'b1, 32'hDEAD_0000 + 32'(w), 32'hFFFF_FFFF, w == BEATW, 1'b0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("drain_valid_before_reset", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("drain_reset_valid", out_valid, 1'b0);
        checkOutput("drain_reset_bits", out_bits, '0);
        checkOutput("drain_reset_marks", out_mb_start, '0);
        checkOutput("drain_reset_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        runVector(BEATW + 3);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        monitorOn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_out_bits", out_bits, '0);
        checkOutput("reset_out_pad", out_pad, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release_in_ready", in_ready, 1'b1);
        checkOutput("release_out_valid", out_valid, 1'b0);

        runVector(BEATW + 3);
        runVector(BEATW + 1);
        stallTest();

        for (int c = 0; c < 2500; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom,
                          ($urandom_range(0, 7) == 0) ? $urandom : 32'h0,
                          $urandom_range(0, 11) == 0,
                          (c % 400 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0));
            @(posedge clk);
            #1;
        end

        resetDrainTest();

        monitorOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
